// File: rtl/irq_dispatch_seq.sv
// Sequencer between an 8-source priority interrupt controller and one handler:
// dispatch the winning ID, await service completion (with timeout), then ack.
module irq_dispatch_seq #(
  parameter int ID_W  = 3,
  parameter int TMO_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             irq_out,
  input  logic [ID_W-1:0]  irq_id,
  output logic             ic_ack,
  output logic             vec_valid,
  output logic [ID_W-1:0]  vec_id,
  input  logic             vec_ready,
  input  logic             svc_done,
  input  logic [TMO_W-1:0] timeout_limit,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_defer,
  output logic [ID_W-1:0]  err_id,
  input  logic             err_clr,
  output logic [CNT_W-1:0] svc_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_SERVICE  = 3'd2;
  localparam logic [2:0] S_ACK      = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [ID_W-1:0]  cur_id;
  logic [TMO_W-1:0] timer;

  logic done_hit;
  logic tmo_hit;
  logic enter_ack;
  logic ack_ok;

  assign done_hit  = (state == S_SERVICE) && svc_done;
  assign tmo_hit   = (state == S_SERVICE) && !svc_done && (timeout_limit != '0) &&
                     (timer == timeout_limit - TMO_W'(1));
  assign enter_ack = done_hit || tmo_hit;
  // The ack decision is taken on the edge that enters ACK so ic_ack can be a
  // register yet still be high during the ACK cycle itself.
  assign ack_ok    = irq_out && (irq_id == cur_id);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (enable && irq_out) state_next = S_DISPATCH;
      S_DISPATCH: if (vec_ready) state_next = S_SERVICE;
      S_SERVICE:  if (enter_ack) state_next = S_ACK;
      S_ACK:      state_next = S_HOLDOFF;
      S_HOLDOFF:  state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      cur_id <= '0;
      timer  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && enable && irq_out) cur_id <= irq_id;
      if (state == S_DISPATCH) timer <= '0;
      else if (state == S_SERVICE) timer <= timer + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ic_ack    <= 1'b0;
      svc_count <= '0;
    end else begin
      ic_ack <= enter_ack && ack_ok;
      if (enter_ack && ack_ok && (svc_count != {CNT_W{1'b1}}))
        svc_count <= svc_count + CNT_W'(1);
    end
  end

  // Clear first, then apply any new error so a simultaneous event wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_timeout <= 1'b0;
      err_defer   <= 1'b0;
      err_id      <= '0;
    end else begin
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_defer   <= 1'b0;
        err_id      <= '0;
      end
      if (tmo_hit) begin
        err_timeout <= 1'b1;
        err_id      <= cur_id;
      end
      if (enter_ack && !ack_ok) begin
        err_defer <= 1'b1;
        err_id    <= cur_id;
      end
    end
  end

  assign vec_valid = (state == S_DISPATCH);
  assign vec_id    = cur_id;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_irq_dispatch_seq.sv
// Bench for irq_dispatch_seq: behavioural 8-source priority controller, a
// scripted handler, and a scoreboard of expected ack IDs.
module tb_irq_dispatch_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        irq_out;
  logic [2:0]  irq_id;
  logic        ic_ack;
  logic        vec_valid;
  logic [2:0]  vec_id;
  logic        vec_ready;
  logic        svc_done;
  logic [15:0] timeout_limit;
  logic        busy;
  logic        err_timeout;
  logic        err_defer;
  logic [2:0]  err_id;
  logic        err_clr;
  logic [15:0] svc_count;

  irq_dispatch_seq dut (
    .clk(clk), .rstn(rstn), .enable(enable), .irq_out(irq_out), .irq_id(irq_id),
    .ic_ack(ic_ack), .vec_valid(vec_valid), .vec_id(vec_id), .vec_ready(vec_ready),
    .svc_done(svc_done), .timeout_limit(timeout_limit), .busy(busy),
    .err_timeout(err_timeout), .err_defer(err_defer), .err_id(err_id),
    .err_clr(err_clr), .svc_count(svc_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: not reset by rstn, so pending bits survive a sequencer reset.
  logic [7:0] pending = 8'h00;
  logic [7:0] set_mask = 8'h00;
  always @(posedge clk)
    pending <= (pending | set_mask) & ~(ic_ack ? (8'h01 << vec_id) : 8'h00);
  assign irq_out = |pending;
  always_comb begin
    irq_id = 3'd0;
    for (int k = 7; k >= 0; k--)
      if (pending[k]) irq_id = k[2:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected ack IDs; popped when the DUT pulses ic_ack.
  logic [2:0] sb[$];
  int ack_cyc[$];
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (ic_ack) begin
      chk("ack_not_consecutive", ack_prev, 0);
      ack_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got ack for id %0d expected no ack", vec_id);
      end else begin
        chk("ack_id", vec_id, sb.pop_front());
      end
    end
    ack_prev = ic_ack;
  end

  task automatic raise(input logic [7:0] mask);
    set_mask = mask;
    @(negedge clk);
    set_mask = 8'h00;
  endtask

  task automatic dispatch(input int rdy, output logic [2:0] id, output int wt);
    wt = 0;
    while (!vec_valid && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    if (!vec_valid) begin
      checks++;
      errors++;
      $display("FAIL dispatch_wait: vec_valid got 0 expected 1 within 40 cycles");
    end
    id = vec_id;
    for (int k = 0; k < rdy; k++) begin
      @(negedge clk);
      chk("stall_valid", vec_valid, 1);
      chk("stall_id", vec_id, id);
    end
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
    chk("service_entry_valid", vec_valid, 0);
  endtask

  // Starts in the first SERVICE cycle; lat = cycles until ic_ack seen, -1 if none.
  task automatic service(input int done_dly, input int bound, output int lat);
    int c;
    c = 0;
    lat = -1;
    while (c <= bound && lat < 0) begin
      if (ic_ack) lat = c;
      else begin
        svc_done = (c == done_dly);
        @(negedge clk);
        svc_done = 1'b0;
        c++;
      end
    end
  endtask

  task automatic finish_seq();
    @(negedge clk);
    chk("holdoff_busy", busy, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic [7:0] pend;
    int         rdy;
    int         done;
    int         tmo;
    logic [2:0] id;
    int         lat;
    logic       terr;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [2:0] id;
    int wt, lat, exp_cnt, n0;

    tbl[0] = '{8'h20, 0,  3, 0, 3'd5, 4, 1'b0};  // single source, done 3 cycles in
    tbl[1] = '{8'h01, 2,  0, 0, 3'd0, 1, 1'b0};
    tbl[2] = '{8'h80, 0, -1, 4, 3'd7, 4, 1'b1};  // timeout, limit 4
    tbl[3] = '{8'h08, 1,  3, 4, 3'd3, 4, 1'b0};  // done on the expiry cycle wins
    tbl[4] = '{8'h40, 0, -1, 1, 3'd6, 1, 1'b1};  // minimum limit
    tbl[5] = '{8'h04, 10, 1, 4, 3'd2, 2, 1'b0};  // long stall, DISPATCH never times out

    rstn = 1'b0; enable = 1'b1; vec_ready = 1'b0; svc_done = 1'b0;
    timeout_limit = 16'd0; err_clr = 1'b0; exp_cnt = 0;
    repeat (3) @(negedge clk);
    chk("rst_ic_ack", ic_ack, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_id", vec_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", {err_timeout, err_defer, err_id}, 0);
    chk("rst_svc_count", svc_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      timeout_limit = 16'(tbl[i].tmo);
      sb.push_back(tbl[i].id);
      exp_cnt++;
      raise(tbl[i].pend);
      dispatch(tbl[i].rdy, id, wt);
      chk("v_dispatch_latency", wt, 1);
      chk("v_vec_id", id, tbl[i].id);
      service(tbl[i].done, 20, lat);
      chk("v_ack_latency", lat, tbl[i].lat);
      chk("v_err_timeout", err_timeout, tbl[i].terr);
      if (tbl[i].terr) chk("v_err_id", err_id, tbl[i].id);
      finish_seq();
      chk("v_svc_count", svc_count, exp_cnt);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("v_err_clr", {err_timeout, err_id}, 0);
    end

    // Back-to-back: IDs 2 and 6 pending together, served in priority order.
    timeout_limit = 16'd0;
    sb.push_back(3'd2);
    sb.push_back(3'd6);
    exp_cnt += 2;
    n0 = ack_cyc.size();
    raise(8'h44);
    dispatch(0, id, wt);
    chk("b2b_first_id", id, 2);
    service(1, 10, lat);
    chk("b2b_first_lat", lat, 2);
    dispatch(0, id, wt);
    chk("b2b_second_id", id, 6);
    service(1, 10, lat);
    chk("b2b_second_lat", lat, 2);
    finish_seq();
    chk("b2b_ack_pulses", ack_cyc.size(), n0 + 2);
    if (ack_cyc.size() >= n0 + 2)
      chk("b2b_gap_ge4", (ack_cyc[n0 + 1] - ack_cyc[n0]) >= 4, 1);
    chk("b2b_svc_count", svc_count, exp_cnt);

    // Enable low blocks dispatch; dropping it mid-sequence does not abort.
    enable = 1'b0;
    raise(8'h08);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("disabled_no_dispatch", {vec_valid, busy}, 0);
    end
    sb.push_back(3'd3);
    exp_cnt++;
    enable = 1'b1;
    dispatch(0, id, wt);
    chk("enable_id", id, 3);
    enable = 1'b0;
    service(2, 10, lat);
    chk("enable_mid_lat", lat, 3);
    finish_seq();
    enable = 1'b1;
    chk("enable_svc_count", svc_count, exp_cnt);

    // Deferral: ID 1 overtakes ID 4 during service; 4 is redispatched after 1.
    raise(8'h10);
    dispatch(0, id, wt);
    chk("defer_first_id", id, 4);
    sb.push_back(3'd1);
    sb.push_back(3'd4);
    exp_cnt += 2;
    raise(8'h02);
    service(1, 4, lat);
    chk("defer_no_ack", lat, -1);
    chk("defer_err_defer", err_defer, 1);
    chk("defer_err_id", err_id, 4);
    dispatch(0, id, wt);
    chk("defer_second_id", id, 1);
    service(0, 10, lat);
    chk("defer_second_lat", lat, 1);
    dispatch(0, id, wt);
    chk("defer_third_id", id, 4);
    service(0, 10, lat);
    chk("defer_third_lat", lat, 1);
    finish_seq();
    chk("defer_svc_count", svc_count, exp_cnt);

    // Reset in SERVICE: outputs clear at once, pending bit survives in the controller.
    sb.push_back(3'd5);
    raise(8'h20);
    dispatch(0, id, wt);
    chk("reset_seq_id", id, 5);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("reset_async_outputs", {ic_ack, vec_valid, vec_id, busy, err_timeout, err_defer, err_id}, 0);
    chk("reset_async_count", svc_count, 0);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    rstn = 1'b1;
    exp_cnt = 1;
    dispatch(0, id, wt);
    chk("reset_redispatch_id", id, 5);
    service(0, 10, lat);
    chk("reset_redispatch_lat", lat, 1);
    finish_seq();
    chk("reset_svc_count", svc_count, exp_cnt);
    chk("pending_empty", pending, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time got 200000 expected completion earlier");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/irq_dispatch_seq.md
# irq_dispatch_seq

Sequencer between the 8-input priority interrupt controller and a single interrupt handler (CPU or microcode engine). It takes the controller's `irq_out`/`irq_id`, hands the winning ID to the handler over a valid/ready handshake, and waits for service completion under a programmable timeout. It then issues the one-cycle `ack` pulse that clears the pending bit. It also keeps sticky error status and a serviced-interrupt counter for software.

## Interface

- `ID_W`, default 3: interrupt ID width; matches the controller's 8 sources.
- `TMO_W`, default 16: width of the service timeout counter and limit.
- `CNT_W`, default 16: width of the saturating serviced counter.

- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `enable` in 1: permits new dispatches; has no effect on a dispatch already in progress.
- `irq_out` in 1: controller "any pending" flag.
- `irq_id` in ID_W: controller highest-priority ID (0 = highest).
- `ic_ack` out 1: one-cycle acknowledge pulse to the controller.
- `vec_valid` out 1: ID offered to the handler.
- `vec_id` out ID_W: latched ID being serviced.
- `vec_ready` in 1: handler accepts the offered ID.
- `svc_done` in 1: handler finished servicing.
- `timeout_limit` in TMO_W: maximum cycles in SERVICE; 0 disables the timeout.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; a service timed out.
- `err_defer` out 1: sticky; an ack was withheld because the ID changed.
- `err_id` out ID_W: ID of the most recent error event.
- `err_clr` in 1: clears `err_timeout`, `err_defer` and `err_id`.
- `svc_count` out CNT_W: number of acks issued, saturating.

## Operation

- States:
  - IDLE: if `enable && irq_out`, latch `irq_id` into `cur_id` and go to DISPATCH.
  - DISPATCH: `vec_valid=1`, `vec_id=cur_id`. Hold until `vec_ready`, with no timeout. On handshake, clear the timer and go to SERVICE.
  - SERVICE: the timer increments each cycle. `svc_done` goes to ACK. If `timeout_limit!=0` and the timer reaches `timeout_limit-1` without `svc_done`: set `err_timeout`, set `err_id=cur_id`, go to ACK.
  - ACK:
    - If `irq_out && irq_id==cur_id`: `ic_ack=1` for this cycle only, and `svc_count` increments (saturating at all-ones).
    - Otherwise: no ack; set `err_defer` and `err_id=cur_id`. The bit stays pending in the controller and is redispatched later.
    - Always go to HOLDOFF.
  - HOLDOFF: one cycle so the controller's updated pending state is visible, then go to IDLE.
- `svc_done` is sampled only in SERVICE. It is ignored in all other states.
- `svc_done` in the same cycle as timeout expiry: done wins and no error is flagged.
- `enable` deasserted mid-sequence: the sequence completes normally; only the IDLE exit is blocked.
- `irq_id` changing during DISPATCH or SERVICE does not alter `cur_id` (no preemption).
- `err_clr` and an error event in the same cycle: the set wins.
- `ic_ack` is never asserted outside ACK, and never on two consecutive cycles.

## Timing

- Reset state: IDLE. All outputs reset to 0: `ic_ack`, `vec_valid`, `vec_id`, `busy`, `err_*`, `svc_count`. `cur_id` and the timer also reset to 0.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- `irq_out` high in IDLE at cycle 0 -> `vec_valid` high at cycle 1. With `vec_ready` at cycle 1, SERVICE begins at cycle 2.
- `svc_done` at cycle N -> `ic_ack` at N+1 -> HOLDOFF at N+2 -> IDLE at N+3 -> next `vec_valid` at N+4 at the earliest.
- Timeout with limit L: entering SERVICE at cycle S without done -> ACK at cycle S+L.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. No ack is issued, so the pending bit survives in the controller only if the controller itself is not reset.

## Test plan

- Single source: controller pending bit 5 set, `vec_ready` held 1, `svc_done` 3 cycles after entering SERVICE -> `vec_id=5`; one `ic_ack` pulse; `svc_count=1`; `busy` low 2 cycles after the ack.
- Back-to-back: bits 2 and 6 pending -> ID 2 serviced and acked first, then ID 6. Two separate ack pulses at least 4 cycles apart; `svc_count=2`.
- Timeout: `timeout_limit=4`, no `svc_done` -> ack exactly 4 cycles after SERVICE entry; `err_timeout=1`, `err_id` equals the latched ID. `err_clr` then returns both to 0.
- Deferral: ID 4 in service, bit 1 becomes pending before done -> no `ic_ack`, `err_defer=1`. ID 1 is dispatched next, then ID 4 again.
- Handshake stall and enable: `vec_ready` low 10 cycles -> `vec_valid` held with stable `vec_id` and no timeout. `enable=0` with `irq_out=1` in IDLE -> no dispatch.
- Reset mid-SERVICE -> all outputs 0 the cycle after `rstn` falls. After release, the still-pending ID is redispatched.
